// File: rtl/heater_pwm_driver_pkg.sv
// Shared types and constants for the heater PWM driver.
// Mode encoding is visible on the mode pin, so values are fixed.
package heater_pwm_driver_pkg;

  typedef enum logic [1:0] {
    MODE_HEAT = 2'd0,
    MODE_DEAD = 2'd1,
    MODE_COOL = 2'd2
  } mode_e;

  localparam logic [7:0] PWM_MAX = 8'd254;

  function automatic logic duty_on(
    input logic [7:0] cnt,
    input logic [7:0] lvl
  );
    return cnt < lvl;
  endfunction

endpackage

// File: rtl/heater_pwm_driver_tick_divider.sv
// Prescaler: one tick every PRESCALE clocks.
// Tick is high in the last clock of each prescale window.
module heater_pwm_driver_tick_divider #(
  parameter int PRESCALE = 4
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  assign tick = (pre_q == LAST);

  always_comb begin
    pre_d = pre_q + PW'(1);
    if (tick) pre_d = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) pre_q <= '0;
    else        pre_q <= pre_d;
  end

endmodule

// File: rtl/heater_pwm_driver.sv
// Heater PWM / cooler enable driver with dead-time direction FSM.
// Inputs are latched only at the period wrap so duty never glitches.
module heater_pwm_driver
  import heater_pwm_driver_pkg::*;
#(
  parameter int PRESCALE     = 4,
  parameter int DEAD_PERIODS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] level,
  input  logic       neg,
  output logic       heat_pwm,
  output logic       cool_on,
  output logic       period_start,
  output logic [1:0] mode
);

  localparam int DW = $clog2(DEAD_PERIODS + 1);
  localparam logic [DW-1:0] DEAD_INIT = DW'(DEAD_PERIODS);

  logic          tick;
  logic          boundary;

  logic [7:0]    cnt_q,  cnt_d;
  logic [7:0]    lvl_q,  lvl_d;
  logic          neg_q,  neg_d;
  mode_e         mode_q, mode_d;
  mode_e         tgt_q,  tgt_d;
  logic [DW-1:0] dead_q, dead_d;
  logic          heat_q, heat_d;
  logic          cool_q, cool_d;
  logic          ps_q,   ps_d;

  heater_pwm_driver_tick_divider #(
    .PRESCALE(PRESCALE)
  ) u_div (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  assign boundary = tick && (cnt_q == PWM_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (tick) cnt_d = boundary ? 8'd0 : cnt_q + 8'd1;
  end

  always_comb begin
    lvl_d = lvl_q;
    neg_d = neg_q;
    if (boundary) begin
      lvl_d = level;
      neg_d = neg;
    end
  end

  // Direction FSM; target is frozen on DEAD entry.
  always_comb begin
    mode_d = mode_q;
    tgt_d  = tgt_q;
    dead_d = dead_q;
    if (boundary) begin
      unique case (mode_q)
        MODE_HEAT: begin
          if (neg_d) begin
            mode_d = MODE_DEAD;
            tgt_d  = MODE_COOL;
            dead_d = DEAD_INIT;
          end
        end
        MODE_COOL: begin
          if (!neg_d) begin
            mode_d = MODE_DEAD;
            tgt_d  = MODE_HEAT;
            dead_d = DEAD_INIT;
          end
        end
        MODE_DEAD: begin
          dead_d = dead_q - DW'(1);
          if (dead_q == DW'(1)) mode_d = tgt_q;
        end
        default: begin
          mode_d = MODE_HEAT;
          dead_d = '0;
        end
      endcase
    end
  end

  // Both drives derive from the same next mode, so they can never overlap.
  always_comb begin
    heat_d = (mode_d == MODE_HEAT) && duty_on(cnt_d, lvl_d);
    cool_d = (mode_d == MODE_COOL);
    ps_d   = boundary;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q  <= 8'd0;
      lvl_q  <= 8'd0;
      neg_q  <= 1'b0;
      mode_q <= MODE_HEAT;
      tgt_q  <= MODE_HEAT;
      dead_q <= '0;
      heat_q <= 1'b0;
      cool_q <= 1'b0;
      ps_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      neg_q  <= neg_d;
      mode_q <= mode_d;
      tgt_q  <= tgt_d;
      dead_q <= dead_d;
      heat_q <= heat_d;
      cool_q <= cool_d;
      ps_q   <= ps_d;
    end
  end

  assign heat_pwm     = heat_q;
  assign cool_on      = cool_q;
  assign period_start = ps_q;
  assign mode         = mode_q;

endmodule

// File: tb/tb_heater_pwm_driver.sv
// Bench for heater_pwm_driver: PRESCALE=1 and PRESCALE=4 instances
// share stimulus and are each tracked by a period-level model.
module tb_heater_pwm_driver;

  localparam int DEADP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] level;
  logic       neg;

  logic       hp [2];
  logic       co [2];
  logic       ps [2];
  logic [1:0] md [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  heater_pwm_driver #(.PRESCALE(1), .DEAD_PERIODS(DEADP)) dut1 (
    .clock       (clk),
    .reset       (rst),
    .level       (level),
    .neg         (neg),
    .heat_pwm    (hp[0]),
    .cool_on     (co[0]),
    .period_start(ps[0]),
    .mode        (md[0])
  );

  heater_pwm_driver #(.PRESCALE(4), .DEAD_PERIODS(DEADP)) dut4 (
    .clock       (clk),
    .reset       (rst),
    .level       (level),
    .neg         (neg),
    .heat_pwm    (hp[1]),
    .cool_on     (co[1]),
    .period_start(ps[1]),
    .mode        (md[1])
  );

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  // Model: clocks since release -> position in period; mode history
  // advances once per period from the neg value seen at the wrap.
  int   n  [2];
  int   ml [2];
  int   mm [2];
  int   dl [2];
  int   tg [2];
  logic eh [2];
  logic ec [2];
  logic eps[2];
  bit   mvalid = 0;

  function automatic int pre_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst) begin
          n[d] = 0; ml[d] = 0; mm[d] = 0; dl[d] = 0; tg[d] = 0;
          eh[d] = 0; ec[d] = 0; eps[d] = 0;
        end else begin
          int c;
          bit bnd;
          n[d] = n[d] + 1;
          c   = (n[d] / pre_of(d)) % 255;
          bnd = (n[d] % (255 * pre_of(d))) == 0;
          if (bnd) begin
            ml[d] = int'(level);
            if (mm[d] == 1) begin
              dl[d] = dl[d] - 1;
              if (dl[d] == 0) mm[d] = tg[d];
            end else if (mm[d] == 0 && neg) begin
              mm[d] = 1; dl[d] = DEADP; tg[d] = 2;
            end else if (mm[d] == 2 && !neg) begin
              mm[d] = 1; dl[d] = DEADP; tg[d] = 0;
            end
          end
          eh[d]  = (mm[d] == 0) && (c < ml[d]);
          ec[d]  = (mm[d] == 2);
          eps[d] = bnd;
        end
      end
      mvalid = 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mvalid) begin
        for (int d = 0; d < 2; d++) begin
          check($sformatf("heat_pwm[%0d]", d), 32'(hp[d]), 32'(eh[d]));
          check($sformatf("cool_on[%0d]", d), 32'(co[d]), 32'(ec[d]));
          check($sformatf("period_start[%0d]", d), 32'(ps[d]), 32'(eps[d]));
          check($sformatf("mode[%0d]", d), 32'(md[d]), 32'(mm[d]));
          check($sformatf("exclusive[%0d]", d), 32'(hp[d] & co[d]), 32'd0);
        end
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic goto_ps(input int d, input int lim, output int w);
    w = 0;
    do begin
      step(1);
      w++;
    end while (ps[d] !== 1'b1 && w < lim);
    check("ps_reached", 32'(ps[d]), 32'd1);
  endtask

  task automatic wait_mode(input int d, input logic [1:0] m,
                           input int lim, output int w);
    w = 0;
    do begin
      step(1);
      w++;
    end while (md[d] !== m && w < lim);
    check("mode_reached", 32'(md[d]), 32'(m));
  endtask

  task automatic count_period(input int d, input int len, output int h);
    h = 0;
    for (int i = 0; i < len; i++) begin
      if (hp[d] === 1'b1) h++;
      step(1);
    end
  endtask

  int w, h;

  initial begin
    rst = 1'b0; level = 8'h80; neg = 1'b0;
    step(3);
    check("rst_heat", 32'(hp[0]), 32'd0);
    check("rst_cool", 32'(co[0]), 32'd0);
    check("rst_ps",   32'(ps[0]), 32'd0);
    check("rst_mode", 32'(md[0]), 32'd0);
    rst = 1'b1;
    goto_ps(0, 400, w);
    check("first_ps_delay", 32'(w), 32'd255);
    check("first_heat", 32'(hp[0]), 32'd1);

    count_period(0, 255, h);
    check("duty_80", 32'(h), 32'd128);
    check("period_255", 32'(ps[0]), 32'd1);
    level = 8'h00;
    count_period(0, 255, h);
    count_period(0, 255, h);
    check("duty_00", 32'(h), 32'd0);
    level = 8'hFF;
    count_period(0, 255, h);
    count_period(0, 255, h);
    check("duty_ff", 32'(h), 32'd255);

    level = 8'h40;
    count_period(0, 255, h);
    h = 0;
    for (int i = 0; i < 100; i++) begin
      if (hp[0] === 1'b1) h++;
      step(1);
    end
    level = 8'hC0;
    for (int i = 0; i < 155; i++) begin
      if (hp[0] === 1'b1) h++;
      step(1);
    end
    check("duty_hold_40", 32'(h), 32'd64);
    check("ps_after_hold", 32'(ps[0]), 32'd1);
    count_period(0, 255, h);
    check("duty_c0", 32'(h), 32'd192);

    step(50);
    neg = 1'b1;
    step(10);
    neg = 1'b0;
    goto_ps(0, 400, w);
    check("pulse_mode", 32'(md[0]), 32'd0);
    goto_ps(0, 400, w);
    check("pulse_mode2", 32'(md[0]), 32'd0);

    step(50);
    level = 8'h00;
    neg = 1'b1;
    goto_ps(0, 400, w);
    check("h2c_dead", 32'(md[0]), 32'd1);
    check("h2c_heat_off", 32'(hp[0]), 32'd0);
    check("h2c_cool_off", 32'(co[0]), 32'd0);
    wait_mode(0, 2'd2, 600, w);
    check("h2c_gap", 32'(w), 32'd510);
    check("cool_on", 32'(co[0]), 32'd1);
    step(100);
    check("cool_hold", 32'(co[0]), 32'd1);
    neg = 1'b0;
    goto_ps(0, 400, w);
    check("c2h_dead", 32'(md[0]), 32'd1);
    check("c2h_cool_off", 32'(co[0]), 32'd0);
    wait_mode(0, 2'd0, 600, w);
    check("c2h_gap", 32'(w), 32'd510);

    level = 8'h80;
    neg = 1'b1;
    goto_ps(0, 400, w);
    wait_mode(0, 2'd2, 600, w);
    step(20);
    rst = 1'b0;
    neg = 1'b0;
    step(1);
    check("mrst_cool", 32'(co[0]), 32'd0);
    check("mrst_mode", 32'(md[0]), 32'd0);
    check("mrst_heat", 32'(hp[0]), 32'd0);
    rst = 1'b1;
    goto_ps(0, 400, w);
    check("mrst_ps_delay", 32'(w), 32'd255);
    check("mrst_no_dead", 32'(md[0]), 32'd0);
    check("mrst_heat_on", 32'(hp[0]), 32'd1);

    goto_ps(1, 1100, w);
    check("p4_first_ps", 32'(w), 32'd765);
    count_period(1, 1020, h);
    check("p4_duty_80", 32'(h), 32'd512);
    check("p4_period", 32'(ps[1]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/heater_pwm_driver.md
Name: heater_pwm_driver

Overview:
Actuator-side consumer of the controller's level/neg command pair. It converts the 8-bit drive level into a glitch-free heater PWM waveform and the neg request into a cooler enable. A direction FSM inserts a mandatory dead time so the heater and cooler are never driven together. Sits between the control core and the output pins / power stage.

Parameters:
PRESCALE, 4, clocks per PWM tick (>=1)
DEAD_PERIODS, 2, full PWM periods with both actuators off on every heat<->cool change (>=1)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
level  input  8  drive level from control core; 0x00 = off, 0xFF = 100%
neg    input  1  cooling request from control core
heat_pwm  output  1  heater PWM drive
cool_on  output  1  cooler enable
period_start  output  1  one-cycle pulse in the first clock of each PWM period
mode  output  2  current FSM state (MODE_* encoding)

Behaviour:
- Reset (reset==0 at a rising edge): heat_pwm=0, cool_on=0, period_start=0, mode=MODE_HEAT. Prescaler=0, cnt=0, lvl_q=0, neg_q=0, dead counter=0. Reset mid-operation aborts any dead time immediately.
- Prescaler counts 0..PRESCALE-1. tick is asserted when prescaler==PRESCALE-1.
- cnt is 8-bit and counts 0..254; it advances on tick. 254+tick wraps to 0, so the period is 255 ticks = 255*PRESCALE clocks.
- Boundary: the edge where cnt wraps 254->0. At that edge only:
  - lvl_q<=level and neg_q<=neg.
  - FSM updates.
  - The period_start register is set; it is high for exactly one clock, the first clock with cnt==0.
- Inputs are sampled only at the boundary. Changes or pulses between boundaries are ignored, so duty never changes mid-period.
- Duty: heat_pwm is high whenever mode==MODE_HEAT and cnt<lvl_q. It is a registered output, updated at the same edge as cnt and lvl_q, with no combinational path from the inputs.
  - level 0x00: never high.
  - level 0x80: high 128 of 255 ticks.
  - level 0xFF: continuously high.
- FSM (transitions only at the boundary, evaluated against the newly sampled neg):
  - HEAT: neg==1 -> DEAD, dead counter<=DEAD_PERIODS, target<=COOL. Otherwise stay in HEAT.
  - COOL: neg==0 -> DEAD, dead counter<=DEAD_PERIODS, target<=HEAT. Otherwise stay in COOL.
  - DEAD: decrement the dead counter at each boundary. When it reaches 0, go to target.
    - target is fixed at DEAD entry.
    - If neg flips during DEAD, the new direction is handled by a fresh DEAD sequence after arrival.
- Outputs per state:
  - DEAD: both outputs 0 for exactly DEAD_PERIODS full periods.
  - COOL: cool_on=1 continuously and heat_pwm=0; level is ignored.
  - HEAT: cool_on=0.
- Invariant: heat_pwm and cool_on are never 1 in the same cycle, including on the cycle of any transition.
- Latency: a level change takes effect at the next boundary, i.e. worst case 255*PRESCALE clocks later.

Decomposition:
- Shared package holds:
  - MODE_HEAT=2'd0, MODE_DEAD=2'd1, MODE_COOL=2'd2 (mode encoding).
  - PWM_MAX=8'd254.
- One natural sub-module: tick_divider (PRESCALE prescaler producing tick, same clock/reset). The PWM counter, duty compare and FSM stay in the top.

Test Plan:
(PRESCALE=1, DEAD_PERIODS=2 unless stated.)
1. Reset behaviour: hold reset low 3 clocks, then release with level=0x80, neg=0.
   -> During reset all outputs 0 and mode=0.
   -> First period_start pulse 255 clocks after release; heat_pwm first goes high in that same cycle.
2. Steady duty: level=0x80, neg=0 steady.
   -> Each 255-clock period has heat_pwm high 128 clocks, then low 127.
   -> cool_on stays 0 and period_start repeats every 255 clocks.
   -> Repeat with 0x00 (always low) and 0xFF (always high).
3. Mid-period level change: switch 0x40 -> 0xC0 at cnt==100.
   -> Current period keeps 64 high clocks.
   -> Next period has 192 high clocks.
4. Heat to cool: set level=0x00, neg=1 mid-period.
   -> At the next boundary mode=1 and both outputs 0 for exactly 510 clocks.
   -> Then mode=2 and cool_on=1 continuously.
   -> Clearing neg returns to heat with the same 510-clock gap.
   -> Assert heat_pwm & cool_on is never 1 throughout.
5. Ignored pulses:
   -> A neg pulse of 10 clocks not covering a boundary: mode stays 0 and there is no dead time.
   -> With PRESCALE=4: period = 1020 clocks and duty scales 4x.
6. Reset mid-operation: assert reset during COOL.
   -> Next clock: cool_on=0, mode=0, cnt=0.
   -> After release, HEAT is entered without dead time.
